// File: rtl/video_mix_pkg.sv
// Shared types and constants for the video layer mixer: inversion modes and
// the palette power-up value.
package video_mix_pkg;

    typedef enum logic [1:0] {
        INV_OFF   = 2'd0,
        INV_FRAME = 2'd1,
        INV_BLINK = 2'd2,
        INV_FORCE = 2'd3
    } inv_mode_e;

    localparam int MAX_COLOR_W = 8;

    // Mid-grey {R,G,B} entry (each component 2^(color_w-1)-1), right-aligned
    // in a field wide enough for the largest supported component width.
    function automatic logic [3*MAX_COLOR_W-1:0] pal_reset_value(input int color_w);
        logic [3*MAX_COLOR_W-1:0] v;
        logic [MAX_COLOR_W-1:0]   c;
        c = MAX_COLOR_W'((1 << (color_w - 1)) - 1);
        v = '0;
        for (int k = 0; k < 3; k++) begin
            v = v | ((3*MAX_COLOR_W)'(c) << (k * color_w));
        end
        return v;
    endfunction

endpackage

// File: rtl/video_layer_mixer_if.sv
// Pixel, timing, control and palette-write signals of the layer mixer.
interface video_layer_mixer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4
);
    localparam int ADDR_W = $clog2(NUM_LAYERS);

    logic                  ce_pix;
    logic [NUM_LAYERS-1:0] layer_in;
    logic                  flash_in;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  hblank_in;
    logic                  vblank_in;
    logic                  color_mode;
    logic [1:0]            inv_mode;
    logic                  pal_we;
    logic                  pal_bank;
    logic [ADDR_W-1:0]     pal_addr;
    logic [3*COLOR_W-1:0]  pal_data;
    logic [COLOR_W-1:0]    r_out;
    logic [COLOR_W-1:0]    g_out;
    logic [COLOR_W-1:0]    b_out;
    logic                  hsync_out;
    logic                  vsync_out;
    logic                  hblank_out;
    logic                  vblank_out;
    logic                  inv_active;

    modport master (
        output ce_pix, layer_in, flash_in, hsync_in, vsync_in, hblank_in, vblank_in,
        output color_mode, inv_mode, pal_we, pal_bank, pal_addr, pal_data,
        input  r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out,
        input  inv_active
    );

    modport slave (
        input  ce_pix, layer_in, flash_in, hsync_in, vsync_in, hblank_in, vblank_in,
        input  color_mode, inv_mode, pal_we, pal_bank, pal_addr, pal_data,
        output r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out,
        output inv_active
    );
endinterface

// File: rtl/mix_palette.sv
// Two-bank layer palette held in flops: one write port, one read port per
// layer for the currently selected bank.
module mix_palette
    import video_mix_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    localparam int ADDR_W    = $clog2(NUM_LAYERS),
    localparam int ENTRY_W   = 3 * COLOR_W
) (
    input  logic                               clk_sys,
    input  logic                               reset_n,
    input  logic                               we,
    input  logic                               wr_bank,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [ENTRY_W-1:0]                 wr_data,
    input  logic                               rd_bank,
    output logic [NUM_LAYERS-1:0][ENTRY_W-1:0] rd_data
);

    localparam logic [ENTRY_W-1:0] RESET_ENTRY = ENTRY_W'(pal_reset_value(COLOR_W));

    logic [1:0][NUM_LAYERS-1:0][ENTRY_W-1:0] pal_q;

    // Entry update; runs every clock so writes never wait for a pixel slot.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pal_q <= {(2*NUM_LAYERS){RESET_ENTRY}};
        end else if (we && (int'(wr_addr) < NUM_LAYERS)) begin
            pal_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = pal_q[rd_bank];

endmodule

// File: rtl/video_layer_mixer.sv
// Mixes 1-bit video layers through a palette into RGB with saturation,
// frame-synchronous flash inversion and blanking; two pixel-enable stages.
module video_layer_mixer
    import video_mix_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    parameter int BLINK_LOG2 = 3
) (
    input logic                 clk_sys,
    input logic                 reset_n,
    video_layer_mixer_if.slave  vif
);

    localparam int ENTRY_W = 3 * COLOR_W;
    localparam int SUM_W   = COLOR_W + $clog2(NUM_LAYERS);
    localparam int CNT_W   = BLINK_LOG2 + 1;

    // Clamp a layer sum to the output component range.
    function automatic logic [COLOR_W-1:0] sat_color(input logic [SUM_W-1:0] s);
        if (|s[SUM_W-1:COLOR_W]) begin
            return '1;
        end
        return s[COLOR_W-1:0];
    endfunction

    logic [NUM_LAYERS-1:0][ENTRY_W-1:0] pal_rd;

    mix_palette #(
        .NUM_LAYERS(NUM_LAYERS),
        .COLOR_W   (COLOR_W)
    ) u_palette (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .we      (vif.pal_we),
        .wr_bank (vif.pal_bank),
        .wr_addr (vif.pal_addr),
        .wr_data (vif.pal_data),
        .rd_bank (vif.color_mode),
        .rd_data (pal_rd)
    );

    // ---------------- frame-level inversion control ----------------
    logic             vs_prev;
    logic             sticky;
    logic             latched;
    logic [CNT_W-1:0] frame_cnt;
    logic             inv_active;
    logic             frame_edge;
    logic             sticky_nx;
    logic             latched_nx;
    logic [CNT_W-1:0] frame_cnt_nx;
    logic             inv_nx;
    inv_mode_e        mode;

    assign frame_edge = vif.ce_pix & vif.vsync_in & ~vs_prev;
    assign mode       = inv_mode_e'(vif.inv_mode);

    // Next flash/frame state; inversion is derived from the post-edge values
    // so a new frame's setting is applied from its very first pixel.
    always_comb begin
        sticky_nx    = sticky;
        latched_nx   = latched;
        frame_cnt_nx = frame_cnt;
        inv_nx       = 1'b0;
        if (frame_edge) begin
            latched_nx   = sticky;
            sticky_nx    = vif.flash_in;
            frame_cnt_nx = frame_cnt + CNT_W'(1);
        end else if (vif.ce_pix & vif.flash_in & ~vif.hblank_in & ~vif.vblank_in) begin
            sticky_nx = 1'b1;
        end
        case (mode)
            INV_OFF:   inv_nx = 1'b0;
            INV_FRAME: inv_nx = latched_nx;
            INV_BLINK: inv_nx = latched_nx & frame_cnt_nx[BLINK_LOG2];
            INV_FORCE: inv_nx = 1'b1;
            default:   inv_nx = 1'b0;
        endcase
    end

    // Flash/frame state registers; inversion follows mode every clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev    <= 1'b0;
            sticky     <= 1'b0;
            latched    <= 1'b0;
            frame_cnt  <= '0;
            inv_active <= 1'b0;
        end else begin
            sticky     <= sticky_nx;
            latched    <= latched_nx;
            frame_cnt  <= frame_cnt_nx;
            inv_active <= inv_nx;
            if (vif.ce_pix) begin
                vs_prev <= vif.vsync_in;
            end
        end
    end

    // ---------------- stage 1: palette lookup per layer ----------------
    logic [NUM_LAYERS-1:0][ENTRY_W-1:0] term_p1;
    logic                               hs_p1, vs_p1, hb_p1, vb_p1;

    // Gate each layer's palette entry by its pixel bit; carry timing along.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            term_p1 <= '0;
            hs_p1   <= 1'b0;
            vs_p1   <= 1'b0;
            hb_p1   <= 1'b0;
            vb_p1   <= 1'b0;
        end else if (vif.ce_pix) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                term_p1[i] <= vif.layer_in[i] ? pal_rd[i] : '0;
            end
            hs_p1 <= vif.hsync_in;
            vs_p1 <= vif.vsync_in;
            hb_p1 <= vif.hblank_in;
            vb_p1 <= vif.vblank_in;
        end
    end

    // ---------------- stage 2: sum, saturate, invert, blank ----------------
    logic [SUM_W-1:0]   sum_r, sum_g, sum_b;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
    logic [COLOR_W-1:0] r_p2, g_p2, b_p2;
    logic               hs_p2, vs_p2, hb_p2, vb_p2;

    // Per-component sum across all layers, wide enough never to overflow.
    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sum_r = sum_r + SUM_W'(term_p1[i][3*COLOR_W-1 -: COLOR_W]);
            sum_g = sum_g + SUM_W'(term_p1[i][2*COLOR_W-1 -: COLOR_W]);
            sum_b = sum_b + SUM_W'(term_p1[i][COLOR_W-1   -: COLOR_W]);
        end
        pix_r = sat_color(sum_r) ^ {COLOR_W{inv_active}};
        pix_g = sat_color(sum_g) ^ {COLOR_W{inv_active}};
        pix_b = sat_color(sum_b) ^ {COLOR_W{inv_active}};
    end

    // Output register; blanking forces black even when inverting.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p2  <= '0;
            g_p2  <= '0;
            b_p2  <= '0;
            hs_p2 <= 1'b0;
            vs_p2 <= 1'b0;
            hb_p2 <= 1'b0;
            vb_p2 <= 1'b0;
        end else if (vif.ce_pix) begin
            if (hb_p1 | vb_p1) begin
                r_p2 <= '0;
                g_p2 <= '0;
                b_p2 <= '0;
            end else begin
                r_p2 <= pix_r;
                g_p2 <= pix_g;
                b_p2 <= pix_b;
            end
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
            hb_p2 <= hb_p1;
            vb_p2 <= vb_p1;
        end
    end

    assign vif.r_out      = r_p2;
    assign vif.g_out      = g_p2;
    assign vif.b_out      = b_p2;
    assign vif.hsync_out  = hs_p2;
    assign vif.vsync_out  = vs_p2;
    assign vif.hblank_out = hb_p2;
    assign vif.vblank_out = vb_p2;
    assign vif.inv_active = inv_active;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer: 4-layer/4-bit instance plus an
// 8-layer/8-bit instance sharing clock and reset.
module tb_video_layer_mixer;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    video_layer_mixer_if #(.NUM_LAYERS(4), .COLOR_W(4)) vif4 ();
    video_layer_mixer_if #(.NUM_LAYERS(8), .COLOR_W(8)) vif8 ();

    video_layer_mixer #(.NUM_LAYERS(4), .COLOR_W(4), .BLINK_LOG2(3)) dut4 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vif     (vif4)
    );

    video_layer_mixer #(.NUM_LAYERS(8), .COLOR_W(8), .BLINK_LOG2(3)) dut8 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vif     (vif8)
    );

    int n_vec = 0;
    int n_err = 0;
    int fcnt_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb4();
        return {20'h0, vif4.r_out, vif4.g_out, vif4.b_out};
    endfunction

    function automatic logic [31:0] rgb8();
        return {8'h0, vif8.r_out, vif8.g_out, vif8.b_out};
    endfunction

    // One pixel-enabled cycle on the 4-layer instance; returns at the next negedge.
    task automatic px4(input logic [3:0] lay, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic fl);
        vif4.ce_pix    = 1'b1;
        vif4.layer_in  = lay;
        vif4.hsync_in  = hs;
        vif4.vsync_in  = vs;
        vif4.hblank_in = hb;
        vif4.vblank_in = vb;
        vif4.flash_in  = fl;
        @(negedge clk_sys);
    endtask

    task automatic idle4(input int n);
        vif4.ce_pix   = 1'b0;
        vif4.flash_in = 1'b0;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic px8(input logic [7:0] lay, input logic hb);
        vif8.ce_pix    = 1'b1;
        vif8.layer_in  = lay;
        vif8.hblank_in = hb;
        @(negedge clk_sys);
    endtask

    // Short frame: 2 vsync/vblank lines then 4 active pixels.
    // fl: 0 none, 1 flash on an active pixel, 2 flash on the vsync edge only.
    task automatic frame4(input int fl, input logic exp_inv, input string tag);
        px4(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, fl == 2);
        chk({tag, "_start"}, vif4.inv_active, exp_inv);
        px4(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, (fl == 1) && (k == 1));
        end
        chk({tag, "_end"}, vif4.inv_active, exp_inv);
        fcnt_m = (fcnt_m + 1) % 16;
    endtask

    initial begin
        logic [3:0] c;
        vif4.ce_pix = 0; vif4.layer_in = 0; vif4.flash_in = 0;
        vif4.hsync_in = 0; vif4.vsync_in = 0; vif4.hblank_in = 0; vif4.vblank_in = 0;
        vif4.color_mode = 0; vif4.inv_mode = 2'd0;
        vif4.pal_we = 0; vif4.pal_bank = 0; vif4.pal_addr = 0; vif4.pal_data = 0;
        vif8.ce_pix = 0; vif8.layer_in = 0; vif8.flash_in = 0;
        vif8.hsync_in = 0; vif8.vsync_in = 0; vif8.hblank_in = 0; vif8.vblank_in = 0;
        vif8.color_mode = 0; vif8.inv_mode = 2'd0;
        vif8.pal_we = 0; vif8.pal_bank = 0; vif8.pal_addr = 0; vif8.pal_data = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);

        chk("rst_rgb",  rgb4(), 32'h0);
        chk("rst_inv",  vif4.inv_active, 32'h0);
        chk("rst_tim",  {vif4.hsync_out, vif4.vsync_out, vif4.hblank_out, vif4.vblank_out}, 32'h0);
        chk("rst_rgb8", rgb8(), 32'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Two grey layers: 7+7 = E, hsync follows the pixel with the same latency
        px4(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hs_lat1", vif4.hsync_out, 32'h0);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mix2", rgb4(), 32'hEEE);
        chk("hs_lat2", vif4.hsync_out, 32'h1);

        // Three grey layers: 21 saturates to F
        px4(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mix3_sat", rgb4(), 32'hFFF);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mix0", rgb4(), 32'h000);

        // Bank1 entry2 rewritten on the same cycle as a layer-2 pixel
        vif4.color_mode = 1'b1;
        vif4.pal_we = 1'b1; vif4.pal_bank = 1'b1; vif4.pal_addr = 2'd2; vif4.pal_data = 12'h0F0;
        px4(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vif4.pal_we = 1'b0;
        px4(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pal_prior", rgb4(), 32'h777);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pal_new", rgb4(), 32'h0F0);
        vif4.color_mode = 1'b0;

        // Forced inversion, blanking wins
        vif4.inv_mode = 2'd3;
        idle4(1);
        chk("force_inv", vif4.inv_active, 32'h1);
        px4(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        px4(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("force_hblank", rgb4(), 32'h000);
        px4(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("force_pix", rgb4(), 32'h888);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("force_vblank", rgb4(), 32'h000);
        vif4.inv_mode = 2'd0;
        idle4(1);
        chk("off_inv", vif4.inv_active, 32'h0);

        // Pixel enable low: both stages hold; palette write still lands
        px4(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px4(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_freeze", rgb4(), 32'hEEE);
        vif4.ce_pix = 1'b0; vif4.layer_in = 4'b1111; vif4.vsync_in = 1'b1; vif4.hblank_in = 1'b1;
        vif4.pal_we = 1'b1; vif4.pal_bank = 1'b0; vif4.pal_addr = 2'd3; vif4.pal_data = 12'h100;
        @(negedge clk_sys);
        vif4.pal_we = 1'b0;
        repeat (9) @(negedge clk_sys);
        chk("freeze_rgb", rgb4(), 32'hEEE);
        chk("freeze_hb", vif4.hblank_out, 32'h0);
        px4(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("thaw_p1", rgb4(), 32'hFFF);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pal_we_no_ce", rgb4(), 32'h100);

        // Frame-latched flash
        vif4.inv_mode = 2'd1;
        frame4(0, 1'b0, "f_pre");
        frame4(1, 1'b0, "f_N");
        frame4(0, 1'b1, "f_N1");
        frame4(0, 1'b0, "f_N2");
        // Flash only on the vsync edge cycle counts toward the new frame
        frame4(2, 1'b0, "e_N1");
        frame4(0, 1'b1, "e_N2");
        frame4(0, 1'b0, "e_N3");

        // Blink: flash every frame, inversion follows frame counter bit 3
        vif4.inv_mode = 2'd2;
        for (int j = 0; j < 18; j++) begin
            c = 4'(fcnt_m + 1);
            frame4(1, (j > 0) && c[3], $sformatf("blink%0d", j));
        end

        // Reset mid-frame after a flash
        vif4.inv_mode = 2'd1;
        vif4.pal_we = 1'b1; vif4.pal_bank = 1'b0; vif4.pal_addr = 2'd0; vif4.pal_data = 12'h123;
        idle4(1);
        vif4.pal_we = 1'b0;
        frame4(1, 1'b1, "r_pre");
        px4(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        px4(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset", rgb4(), 32'hEDC);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_rgb", rgb4(), 32'h0);
        chk("async_rst_hs", vif4.hsync_out, 32'h0);
        chk("async_rst_inv", vif4.inv_active, 32'h0);
        idle4(2);
        reset_n = 1'b1;
        fcnt_m = 0;
        frame4(0, 1'b0, "r_post");
        px4(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pal_grey_b0", rgb4(), 32'h777);
        vif4.color_mode = 1'b1;
        px4(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        px4(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pal_grey_b1", rgb4(), 32'h777);
        idle4(1);

        // 8 layers, 8-bit colour
        px8(8'b0000_0011, 1'b0);
        px8(8'b0000_0000, 1'b0);
        chk("w8_mix2", rgb8(), 32'hFEFEFE);
        px8(8'b0000_0111, 1'b0);
        px8(8'b0000_0000, 1'b0);
        chk("w8_sat", rgb8(), 32'hFFFFFF);
        vif8.pal_we = 1'b1; vif8.pal_bank = 1'b0; vif8.pal_addr = 3'd7; vif8.pal_data = 24'h010203;
        px8(8'b1000_0001, 1'b0);
        vif8.pal_we = 1'b0;
        px8(8'b1000_0001, 1'b0);
        chk("w8_pal_prior", rgb8(), 32'hFEFEFE);
        px8(8'b0000_0000, 1'b0);
        chk("w8_pal_new", rgb8(), 32'h808182);
        vif8.inv_mode = 2'd3;
        px8(8'b0000_0001, 1'b0);
        chk("w8_inv", vif8.inv_active, 32'h1);
        px8(8'b0000_0001, 1'b1);
        chk("w8_force", rgb8(), 32'h808080);
        px8(8'b0000_0000, 1'b0);
        chk("w8_blank", rgb8(), 32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
